sra_share_scheduler: RTL and testbench

//  Round-robin scheduler that shares one SRA_Behavior arithmetic-right-shift unit between two requesters.

---
 rtl/sra_share_scheduler.sv | 110 +++++++++++
 tb/tb_sra_share_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sra_share_scheduler.sv
// Round-robin arbiter that time-shares one arithmetic-right-shift unit between two requesters.
// Optional build macro: SRA_ZERO_BYPASS_EN (zero shift amount completes without using the shifter).
module sra_share_scheduler #(
  parameter int WIDTH       = 8,
  parameter int SRA_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_shamt0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [WIDTH-1:0] req_shamt1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] sra_in1,
  output logic [WIDTH-1:0] sra_in2,
  output logic             sra_start,
  input  logic [WIDTH-1:0] sra_result
);

  localparam int CW = (SRA_LATENCY < 2) ? 1 : $clog2(SRA_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic          ptr;
  logic          sel;
  logic          pick;
  logic [CW-1:0] cnt;

  // Contention goes to the pointer; otherwise the lone requester wins.
  always_comb begin
    pick = req[1];
    if (req == 2'b11) pick = ptr;
  end

  // NOTE: all state and outputs are updated with non-blocking assignments so every
  // register in this block samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: async reset clears every register, including the latched operands.
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      sel       <= 1'b0;
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      result    <= '0;
      sra_in1   <= '0;
      sra_in2   <= '0;
      sra_start <= 1'b0;
    end else begin
      gnt       <= '0;
      done      <= '0;
      sra_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            sel     <= pick;
            gnt     <= {pick, ~pick};
            sra_in1 <= pick ? req_data1  : req_data0;
            sra_in2 <= pick ? req_shamt1 : req_shamt0;
            ptr     <= ~pick;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef SRA_ZERO_BYPASS_EN
          if (sra_in2 == '0) begin
            result <= sra_in1;
            done   <= {sel, ~sel};
            state  <= DONE;
          end else
`endif
          begin
            sra_start <= 1'b1;
            cnt       <= CW'(SRA_LATENCY);
            state     <= WAIT;
          end
        end
        WAIT: begin
          // The countdown begins once the shifter has sampled Start.
          if (sra_start) begin
            cnt <= cnt;
          end else if (cnt == '0) begin
            result <= sra_result;
            done   <= {sel, ~sel};
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sra_share_scheduler.sv
// Self-checking bench for sra_share_scheduler: transaction-level timing model plus
// a behavioural shifter, checked every cycle, with directed literal vectors on top.
module tb_sra_share_scheduler;

  localparam int W = 8;
  localparam int L = 2;
`ifdef SRA_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [W-1:0] req_data0 = '0, req_shamt0 = '0, req_data1 = '0, req_shamt1 = '0;
  logic [1:0]   gnt, done;
  logic [W-1:0] result, sra_in1, sra_in2, sra_result;
  logic         sra_start;

  int checks = 0;
  int errors = 0;

  sra_share_scheduler #(.WIDTH(W), .SRA_LATENCY(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data0  (req_data0),
    .req_shamt0 (req_shamt0),
    .req_data1  (req_data1),
    .req_shamt1 (req_shamt1),
    .gnt        (gnt),
    .done       (done),
    .result     (result),
    .sra_in1    (sra_in1),
    .sra_in2    (sra_in2),
    .sra_start  (sra_start),
    .sra_result (sra_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic logic [W-1:0] sra_ref(input logic [W-1:0] a, input logic [W-1:0] s);
    logic signed [W-1:0] sa;
    sa = a;
    return sa >>> s;
  endfunction

  // Behavioural shifter: result valid L cycles after Start rises, garbage before that.
  logic [W-1:0] sh_pend;
  int           sh_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sra_result <= '0;
      sh_cnt     <= 0;
    end else if (sra_start) begin
      sh_pend    <= sra_ref(sra_in1, sra_in2);
      sra_result <= (L == 1) ? sra_ref(sra_in1, sra_in2) : ~sra_ref(sra_in1, sra_in2);
      sh_cnt     <= L - 1;
    end else if (sh_cnt > 0) begin
      sh_cnt <= sh_cnt - 1;
      if (sh_cnt == 1) sra_result <= sh_pend;
    end
  end

  // Transaction model: each grant schedules its start/done edges and the next free edge.
  int           cyc = 0;
  int           grant_e = -1, start_e = -1, done_e = -1, next_free = 0;
  logic         m_who = 1'b0, m_ptr = 1'b0;
  logic [W-1:0] m_in1 = '0, m_in2 = '0, m_res = '0, m_pend = '0;
  bit           started = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_e = -1; start_e = -1; done_e = -1; next_free = 0;
      m_ptr = 1'b0; m_in1 = '0; m_in2 = '0; m_res = '0;
    end else begin
      cyc++;
      if (cyc == done_e) m_res = m_pend;
      if (cyc >= next_free && req != 2'b00) begin
        m_who   = (req == 2'b11) ? m_ptr : req[1];
        m_in1   = m_who ? req_data1  : req_data0;
        m_in2   = m_who ? req_shamt1 : req_shamt0;
        m_ptr   = ~m_who;
        grant_e = cyc;
        if (BYPASS && m_in2 == '0) begin
          m_pend = m_in1; start_e = -1; done_e = cyc + 1; next_free = cyc + 3;
        end else begin
          m_pend = sra_ref(m_in1, m_in2); start_e = cyc + 1;
          done_e = cyc + L + 3; next_free = cyc + L + 5;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && started) begin
      check("gnt",       32'(gnt),       (cyc == grant_e) ? 32'({m_who, ~m_who}) : 32'd0);
      check("sra_start", 32'(sra_start), 32'(cyc == start_e));
      check("done",      32'(done),      (cyc == done_e) ? 32'({m_who, ~m_who}) : 32'd0);
      check("result",    32'(result),    32'(m_res));
      check("sra_in1",   32'(sra_in1),   32'(m_in1));
      check("sra_in2",   32'(sra_in2),   32'(m_in2));
    end
  end

  int start_cnt = 0, gnt_cnt = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (sra_start) start_cnt++;
    if (gnt != 2'b00) gnt_cnt++;
    if (done != 2'b00) done_cnt++;
  end

  task automatic run_one(input int who, input logic [W-1:0] d, input logic [W-1:0] s,
                         input logic [W-1:0] exp_res, input string name);
    int n;
    int exp_lat;
    exp_lat = (BYPASS && s == '0) ? 1 : L + 3;
    @(negedge clk);
    if (who == 0) begin req_data0 = d; req_shamt0 = s; end
    else begin req_data1 = d; req_shamt1 = s; end
    req[who] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[who] && n < 60);
    if (!done[who]) timeout({name, " done"});
    else begin
      check({name, " latency"}, 32'(n - 1), 32'(exp_lat));
      check({name, " result"},  32'(result), 32'(exp_res));
    end
    req[who] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, g0, n, ng, ns;
    logic [1:0] gseq [4];
    int         st   [3];

    #12;
    check("reset outputs", 32'({gnt, done, result, sra_in1, sra_in2, sra_start}), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    started = 1'b1;

    // Test 1: single request from requester 0.
    s0 = start_cnt; g0 = gnt_cnt;
    run_one(0, 8'hF0, 8'd2, 8'hFC, "t1");
    check("t1 start pulses", 32'(start_cnt - s0), 32'd1);
    check("t1 grants",       32'(gnt_cnt - g0),   32'd1);

    // Test 2 and extra vectors, including shift amounts beyond the width.
    run_one(1, 8'h03, 8'd4,   8'h00, "t2");
    run_one(1, 8'h85, 8'd9,   8'hFF, "big shamt neg");
    run_one(1, 8'h45, 8'd200, 8'h00, "big shamt pos");
    run_one(0, 8'h7F, 8'd1,   8'h3F, "pos by 1");
    run_one(0, 8'h81, 8'd3,   8'hF0, "neg by 3");

    // Test 5: operand changes after grant are ignored.
    @(negedge clk);
    req_data0 = 8'h80; req_shamt0 = 8'd7; req = 2'b01;
    n = 0;
    while (!gnt[0] && n < 20) begin @(negedge clk); n++; end
    if (!gnt[0]) timeout("t5 gnt");
    req_data0 = 8'h7F;
    n = 0;
    while (!done[0] && n < 20) begin @(negedge clk); n++; end
    if (!done[0]) timeout("t5 done");
    else check("t5 result", 32'(result), 32'h0000_00FF);
    req = 2'b00;

    // Test 6: zero shift amount.
    s0 = start_cnt;
    run_one(0, 8'h9A, 8'd0, 8'h9A, "t6");
    check("t6 start pulses", 32'(start_cnt - s0), BYPASS ? 32'd0 : 32'd1);

    // Test 3: both requesting from reset alternate strictly.
    @(negedge clk);
    rst_n = 1'b0;
    req_data0 = 8'hF0; req_shamt0 = 8'd1; req_data1 = 8'h40; req_shamt1 = 8'd2;
    req = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    ng = 0; ns = 0; n = 0;
    while (ng < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (sra_start && ns < 3) begin st[ns] = n; ns++; end
      if (gnt != 2'b00) begin gseq[ng] = gnt; ng++; end
    end
    req = 2'b00;
    if (ng < 4) timeout("t3 grants");
    else begin
      check("t3 grant0", 32'(gseq[0]), 32'd1);
      check("t3 grant1", 32'(gseq[1]), 32'd2);
      check("t3 grant2", 32'(gseq[2]), 32'd1);
      check("t3 grant3", 32'(gseq[3]), 32'd2);
      check("t3 start spacing a", 32'(st[1] - st[0]), 32'(L + 5));
      check("t3 start spacing b", 32'(st[2] - st[1]), 32'(L + 5));
    end
    repeat (12) @(negedge clk);

    // Test 4: reset while the shifter operation is in flight.
    req_data0 = 8'h55; req_shamt0 = 8'd1; req = 2'b01;
    n = 0;
    while (!gnt[0] && n < 20) begin @(negedge clk); n++; end
    if (!gnt[0]) timeout("t4 gnt");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req   = 2'b00;
    #1;
    check("t4 async clear", 32'({gnt, done, result, sra_in1, sra_in2, sra_start}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = start_cnt; g0 = done_cnt;
    repeat (12) @(negedge clk);
    check("t4 no start after reset", 32'(start_cnt - s0), 32'd0);
    check("t4 no done after reset",  32'(done_cnt - g0),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
